// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 32;

    // Sequencer states: normal flow, fence.i drain, icache invalidate, redirect waiting on IF.
    typedef enum logic [1:0] {
        RUN,
        FENCE_WAIT,
        FENCE_INV,
        REDIR_WAIT
    } pipe_ctrl_state_e;

    // Per-stage control pair handed to each pipeline stage.
    typedef struct packed {
        logic ready;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_redirect_hold.sv
// Holds a redirect toward IF until IF is free to accept it. A new request
// always overwrites the held target, so a trap arriving while a branch
// redirect waits replaces it.
module redirect_hold #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [XLEN-1:0] req_target,
    input  logic            if_busy,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_target
);

    logic            pend_q, pend_d;
    logic [XLEN-1:0] target_q, target_d;

    // Capture new requests, clear the pending flag once IF consumes it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pend_d   = pend_q;
        target_d = target_q;
        if (req) begin
            target_d = req_target;
            pend_d   = if_busy;
        end else if (pend_q && !if_busy) begin
            pend_d = 1'b0;
        end
    end

    // Held target and pending flag registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            pend_q   <= 1'b0;
            target_q <= '0;
        end else begin
            pend_q   <= pend_d;
            target_q <= target_d;
        end
    end

    assign redir_valid  = req || pend_q;
    assign redir_target = req ? req_target : target_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: ready chain,
// branch/trap redirects, fence.i drain-invalidate-refetch, ID stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_busy,
    input  logic             id_valid,
    input  logic             id_fence_i,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             exe_valid,
    input  logic             mem_valid,
    input  logic             wb_valid,
    input  logic             exe_busy,
    input  logic             exe_fw_valid,
    input  logic             mem_busy,
    input  logic             br_req,
    input  logic [XLEN-1:0]  br_target,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             icache_inv_ack,
    output logic             if_ready,
    output logic             id_ready,
    output logic             exe_ready,
    output logic             mem_ready,
    output logic             wb_ready,
    output logic             if_flush,
    output logic             id_flush,
    output logic             exe_flush,
    output logic             mem_flush,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_target,
    output logic             icache_inv_req,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_ctrl_state_e state_q, state_d;
    logic             trap_pend_q, trap_pend_d;
    logic [XLEN-1:0]  trap_tgt_q, trap_tgt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             mem_rdy, exe_rdy, id_rdy, id_hold;
    logic             rd_req;
    logic [XLEN-1:0]  rd_target;
    stage_ctrl_t      if_c, id_c, exe_c, mem_c;

    // Ready chain: back-pressure propagates from MEM toward IF; fence.i sits in ID until the ack cycle.
    always_comb begin
        mem_rdy = !mem_busy;
        exe_rdy = mem_rdy && !exe_busy && exe_fw_valid;
        id_hold = id_valid && id_fence_i && !(state_q == FENCE_INV && icache_inv_ack);
        id_rdy  = exe_rdy && !id_hold;
    end

    // Next-state, flush and redirect-request logic.
    always_comb begin
        state_d        = state_q;
        trap_pend_d    = trap_pend_q;
        trap_tgt_d     = trap_tgt_q;
        rd_req         = 1'b0;
        rd_target      = '0;
        icache_inv_req = 1'b0;
        if_c           = '{ready: id_rdy,  flush: 1'b0};
        id_c           = '{ready: id_rdy,  flush: 1'b0};
        exe_c          = '{ready: exe_rdy, flush: 1'b0};
        mem_c          = '{ready: mem_rdy, flush: 1'b0};
        unique case (state_q)
            RUN, FENCE_WAIT: begin
                if (trap_req) begin
                    if_c.flush  = 1'b1;
                    id_c.flush  = 1'b1;
                    exe_c.flush = 1'b1;
                    mem_c.flush = 1'b1;
                    rd_req      = 1'b1;
                    rd_target   = trap_target;
                    state_d     = if_busy ? REDIR_WAIT : RUN;
                end else if (br_req && exe_rdy) begin
                    // An older branch in EXE also kills a fence.i waiting in ID.
                    if_c.flush = 1'b1;
                    id_c.flush = 1'b1;
                    rd_req     = 1'b1;
                    rd_target  = br_target;
                    state_d    = if_busy ? REDIR_WAIT : RUN;
                end else if (state_q == RUN) begin
                    if (id_valid && id_fence_i) state_d = FENCE_WAIT;
                end else if (!exe_valid && !mem_valid && !wb_valid) begin
                    state_d = FENCE_INV;
                end
            end
            FENCE_INV: begin
                icache_inv_req = 1'b1;
                // Downstream is empty here; a trap is only remembered for the refetch.
                if (trap_req) begin
                    trap_pend_d = 1'b1;
                    trap_tgt_d  = trap_target;
                end
                if (icache_inv_ack) begin
                    if_c.flush  = 1'b1;
                    rd_req      = 1'b1;
                    rd_target   = trap_req    ? trap_target :
                                  trap_pend_q ? trap_tgt_q  : id_pc + XLEN'(4);
                    trap_pend_d = 1'b0;
                    state_d     = if_busy ? REDIR_WAIT : RUN;
                end
            end
            REDIR_WAIT: begin
                // Younger path is already gone; branches are ignored, traps retarget.
                if_c.flush = 1'b1;
                if (trap_req) begin
                    id_c.flush  = 1'b1;
                    exe_c.flush = 1'b1;
                    mem_c.flush = 1'b1;
                    rd_req      = 1'b1;
                    rd_target   = trap_target;
                end
                if (!if_busy) state_d = RUN;
            end
        endcase
    end

    // Saturating count of cycles where a valid ID instruction cannot advance.
    always_comb begin
        stall_d = stall_q;
        if (id_valid && !id_rdy && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end

    // State, pending-trap and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            trap_pend_q <= 1'b0;
            trap_tgt_q  <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            trap_pend_q <= trap_pend_d;
            trap_tgt_q  <= trap_tgt_d;
            stall_q     <= stall_d;
        end
    end

    redirect_hold #(.XLEN(XLEN)) u_redirect_hold (
        .clk         (clk),
        .rst         (rst),
        .req         (rd_req),
        .req_target  (rd_target),
        .if_busy     (if_busy),
        .redir_valid (redir_valid),
        .redir_target(redir_target)
    );

    assign wb_ready  = 1'b1;
    assign mem_ready = mem_c.ready;
    assign exe_ready = exe_c.ready;
    assign id_ready  = id_c.ready;
    assign if_ready  = if_c.ready;
    assign if_flush  = if_c.flush;
    assign id_flush  = id_c.flush;
    assign exe_flush = exe_c.flush;
    assign mem_flush = mem_c.flush;
    assign stall_cnt = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID/EXE/MEM/WB). It combines stage-busy signals, the EXE forwarding-valid flag, branch redirects from EXE and traps from WB into per-stage ready/flush controls and a PC redirect handshake toward IF. It also sequences fence.i: drain older instructions, run the icache invalidate handshake, then refetch. It maintains a saturating ID stall-cycle counter.

Parameters:
XLEN, 64, PC/target width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_busy  in  1  IF has an outstanding fetch; cannot accept redirect this cycle
id_valid  in  1  ID holds a valid instruction
id_fence_i  in  1  ID instruction is fence.i
id_pc  in  XLEN  PC of ID instruction
exe_valid  in  1  EXE holds a valid instruction
mem_valid  in  1  MEM holds a valid instruction
wb_valid  in  1  WB holds a valid instruction
exe_busy  in  1  multi-cycle EXE unit (mul/div) not finished
exe_fw_valid  in  1  forwarding unit has all EXE operands
mem_busy  in  1  dcache access not finished
br_req  in  1  EXE branch mispredict/jump redirect
br_target  in  XLEN  branch target
trap_req  in  1  WB trap/xret redirect
trap_target  in  XLEN  trap vector / epc
icache_inv_ack  in  1  icache invalidate complete (1-cycle pulse)
if_ready, id_ready, exe_ready, mem_ready, wb_ready  out  1 each  stage may advance
if_flush, id_flush, exe_flush, mem_flush  out  1 each  kill stage contents
redir_valid  out  1  redirect request to IF
redir_target  out  XLEN  redirect PC
icache_inv_req  out  1  icache invalidate request (level)
stall_cnt  out  CNT_W  saturating ID stall cycles

Behaviour:
- Reset (rst=1 at posedge): state=RUN; held target=0; trap_pend=0; stall_cnt=0. Outputs in the cycle after reset: all flush=0, redir_valid=0, icache_inv_req=0.
- Ready chain (combinational): wb_ready=1; mem_ready=!mem_busy; exe_ready=mem_ready && !exe_busy && exe_fw_valid; id_ready=exe_ready && !id_hold; if_ready=id_ready.
- id_hold=1 when id_valid && id_fence_i && state!=FENCE_INV_DONE_cycle, i.e. fence.i is held in ID until the invalidate ack cycle.
- States: RUN, FENCE_WAIT, FENCE_INV, REDIR_WAIT.
- RUN:
  - trap_req: assert if/id/exe/mem_flush this cycle. Drive redir_valid=1 with target=trap_target. If !if_busy, stay in RUN; else latch the target and go to REDIR_WAIT.
  - else br_req && exe_ready: assert if/id_flush. Redirect to br_target with the same if_busy rule.
  - else id_valid && id_fence_i: go to FENCE_WAIT.
- FENCE_WAIT: id held. When !exe_valid && !mem_valid && !wb_valid, go to FENCE_INV. A trap_req here is handled as in RUN and the fence is dropped (ID flushed).
- FENCE_INV: icache_inv_req=1 until the icache_inv_ack cycle, inclusive. A trap_req here only sets trap_pend and latches trap_target; no flush of the empty downstream stages. On ack:
  - id_hold released, so fence.i advances as a nop; if_flush=1.
  - Redirect target = trap_pend ? latched trap target : id_pc+4, truncated to XLEN.
  - Next state: RUN if !if_busy, else REDIR_WAIT.
- REDIR_WAIT: redir_valid=1 and if_flush=1 every cycle, target held. Leave to RUN on the first cycle with !if_busy, redirect consumed that cycle. A trap_req overwrites the target and asserts exe/mem/id_flush. A br_req is ignored, because the younger path is already flushed.
- Priority: trap_req > br_req > fence.i. A redirect is accepted by IF only when redir_valid && !if_busy.
- stall_cnt increments by 1 each cycle with id_valid && !id_ready, saturating at all-ones.
- Flushes are single-cycle combinational, except the held if_flush in REDIR_WAIT. exe_flush and the forwarding reservation clear are driven from this block.

Decomposition:
- def_common package: typedef enum pipe_ctrl_state_e {RUN, FENCE_WAIT, FENCE_INV, REDIR_WAIT}; typedef struct stage_ctrl {ready, flush} per stage.
- Sub-module redirect_hold: registered target plus pending flag, implementing the trap-overwrites-branch latch and the !if_busy consume rule. The FSM and ready chain stay in pipeline_ctrl.

Test Plan:
- Load-use: exe_fw_valid=0 for 1 cycle → exe/id/if_ready=0 that cycle, mem_ready=1, stall_cnt=1 (id_valid=1); ready returns the next cycle.
- Branch with if_busy=1 for 2 cycles, br_target=0x8000_0100 → if/id_flush pulse, redir_valid high 3 cycles with target 0x8000_0100, state REDIR_WAIT → RUN when if_busy drops.
- Same-cycle trap_req (target 0x8000_0004) and br_req → if/id/exe/mem_flush=1, redir_target=0x8000_0004.
- fence.i at id_pc=0x8000_0200 with exe/mem valid → ID stalls until drained; icache_inv_req high until ack 4 cycles later; then if_flush and redirect to 0x8000_0204.
- Trap during FENCE_INV (trap_target=0x8000_0040) → invalidate completes, redirect to 0x8000_0040, not pc+4.
- rst asserted mid-REDIR_WAIT → next cycle redir_valid=0, icache_inv_req=0, stall_cnt=0, state RUN.
